s7_stoper_ctrl: RTL and testbench

Run-control sequencer for the 6-digit seven-segment stopwatch datapath. It turns three raw push-buttons (start/stop, lap, clear) into counter enable, counter clear, lap capture/freeze and pause-blink controls. It sits between the board buttons and the stopwatch counter/display mux, and runs on the same 1 kHz clock, where 1 cycle is 1 ms.

---
 rtl/s7_stoper_ctrl_pkg.sv | 21 ++
 rtl/s7_debounce.sv | 54 +++++
 rtl/s7_stoper_ctrl.sv | 134 +++++++++++++
 tb/tb_s7_stoper_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/s7_stoper_ctrl_pkg.sv
// Shared definitions for the stopwatch run-control sequencer: state
// encodings, default timing constants and a small output-decode helper.
package s7_stoper_ctrl_pkg;

  // 1 cycle = 1 ms at the 1 kHz stopwatch clock
  localparam int DEF_DEBOUNCE_CYCLES = 20;   // 20 ms of stable level
  localparam int DEF_BLINK_HALF      = 250;  // 250 ms half-period, 2 Hz blink

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_LAP   = 2'd3
  } state_e;

  // The counter keeps running while a lap is frozen on the display
  function automatic logic counts_up(input state_e s);
    return (s == S_RUN) || (s == S_LAP);
  endfunction

endpackage

// File: rtl/s7_debounce.sv
// Button conditioner: 2-flop synchroniser, stable-level debounce and a
// one-cycle pulse on the accepted press (0->1) edge. Releases are silent.
module s7_debounce #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          level_dly_q;
  logic          press_q;

  // Count consecutive samples that disagree with the accepted level; the
  // sample that would make the count DEBOUNCE_CYCLES flips the level instead.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser, debounce state and registered press-edge pulse
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], i_btn};
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= level_q & ~level_dly_q;
    end
  end

  assign o_press = press_q;

endmodule

// File: rtl/s7_stoper_ctrl.sv
// Stopwatch run-control sequencer: debounced start/stop, lap and clear
// buttons drive an IDLE/RUN/PAUSE/LAP machine with registered control
// outputs and a 2 Hz display blink while paused.
module s7_stoper_ctrl
  import s7_stoper_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int BLINK_HALF      = DEF_BLINK_HALF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start_stop,
  input  logic       i_lap,
  input  logic       i_clear,
  output logic       o_cnt_en,
  output logic       o_cnt_clr,
  output logic       o_lap_latch,
  output logic       o_lap_hold,
  output logic       o_blank,
  output logic [1:0] o_state
);

  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  logic [2:0] btn_raw;
  logic [2:0] press;
  logic       sp, lp, cp;

  state_e        state_q, state_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blank_q, blank_d;
  logic          clr_q, clr_d;
  logic          latch_q, latch_d;
  logic          cnt_en_q, lap_hold_q;

  // Bit order: 0 = start/stop, 1 = lap, 2 = clear
  assign btn_raw = {i_clear, i_lap, i_start_stop};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      s7_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_btn  (btn_raw[gi]),
        .o_press(press[gi])
      );
    end
  endgenerate

  assign sp = press[0];
  assign lp = press[1];
  assign cp = press[2];

  // Next state and pulses; within each state the first acting press in
  // clear > start/stop > lap order wins and the others are dropped.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    latch_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (cp)      clr_d   = 1'b1;
        else if (sp) state_d = S_RUN;
      end
      S_RUN: begin
        if (sp) begin
          state_d = S_PAUSE;
        end else if (lp) begin
          state_d = S_LAP;
          latch_d = 1'b1;
        end
      end
      S_LAP: begin
        if (sp)      state_d = S_PAUSE;
        else if (lp) state_d = S_RUN;
      end
      S_PAUSE: begin
        if (cp) begin
          state_d = S_IDLE;
          clr_d   = 1'b1;
        end else if (sp) begin
          state_d = S_RUN;
        end
      end
    endcase
  end

  // Blink runs only while staying in PAUSE; entering or leaving restarts it dark
  always_comb begin
    blink_cnt_d = '0;
    blank_d     = 1'b0;
    if (state_q == S_PAUSE && state_d == S_PAUSE) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blank_d = ~blank_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        blank_d     = blank_q;
      end
    end
  end

  // State register with all outputs registered from the next state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      blink_cnt_q <= '0;
      blank_q     <= 1'b0;
      clr_q       <= 1'b0;
      latch_q     <= 1'b0;
      cnt_en_q    <= 1'b0;
      lap_hold_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      blink_cnt_q <= blink_cnt_d;
      blank_q     <= blank_d;
      clr_q       <= clr_d;
      latch_q     <= latch_d;
      cnt_en_q    <= counts_up(state_d);
      lap_hold_q  <= (state_d == S_LAP);
    end
  end

  assign o_cnt_en    = cnt_en_q;
  assign o_cnt_clr   = clr_q;
  assign o_lap_latch = latch_q;
  assign o_lap_hold  = lap_hold_q;
  assign o_blank     = blank_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_s7_stoper_ctrl.sv
// Bench for s7_stoper_ctrl: every output change is an event; the stimulus
// side queues the expected (edge, outputs) events and a monitor pops and
// compares them as the DUT produces them.
module tb_s7_stoper_ctrl;
  import s7_stoper_ctrl_pkg::*;

  localparam int DEB   = DEF_DEBOUNCE_CYCLES;
  localparam int BLINK = DEF_BLINK_HALF;
  localparam int LAT   = DEB + 3;  // first raw sample edge -> state edge
  localparam int GAP   = 30;       // idle after release so it debounces back

  typedef struct {
    int         cyc;
    logic [6:0] val;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sp = 1'b0, lp = 1'b0, cp = 1'b0;
  logic       o_cnt_en, o_cnt_clr, o_lap_latch, o_lap_hold, o_blank;
  logic [1:0] o_state;

  int   edge_n   = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  rec_t exp_q[$];
  rec_t rec;
  logic       mon_en = 1'b0;
  logic [6:0] cur_vec, prev_vec;

  // Reference model state
  state_e m_state     = S_IDLE;
  logic   m_blank     = 1'b0;
  int     m_toggle_at = 0;

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  s7_stoper_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .BLINK_HALF     (BLINK)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_start_stop(sp),
    .i_lap       (lp),
    .i_clear     (cp),
    .o_cnt_en    (o_cnt_en),
    .o_cnt_clr   (o_cnt_clr),
    .o_lap_latch (o_lap_latch),
    .o_lap_hold  (o_lap_hold),
    .o_blank     (o_blank),
    .o_state     (o_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  // Output vector: {state[1:0], cnt_en, cnt_clr, lap_latch, lap_hold, blank}
  function automatic logic [6:0] pack(input logic clr, input logic lat);
    logic en, hold;
    en   = (m_state == S_RUN) || (m_state == S_LAP);
    hold = (m_state == S_LAP);
    return {m_state, en, clr, lat, hold, m_blank};
  endfunction

  task automatic push(input int t, input logic [6:0] v);
    rec_t r;
    r.cyc = t;
    r.val = v;
    exp_q.push_back(r);
  endtask

  // Queue blink toggles that fall strictly before edge t
  task automatic advance_to(input int t);
    while (m_state == S_PAUSE && m_toggle_at < t) begin
      m_blank = ~m_blank;
      push(m_toggle_at, pack(1'b0, 1'b0));
      m_toggle_at += BLINK;
    end
  endtask

  // Apply one accepted press set to the model, effective at edge t
  task automatic model_step(input logic psp, input logic plp, input logic pcp, input int t);
    state_e nxt;
    logic   clr, lat;
    nxt = m_state;
    clr = 1'b0;
    lat = 1'b0;
    case (m_state)
      S_IDLE:  if (pcp) clr = 1'b1; else if (psp) nxt = S_RUN;
      S_RUN:   if (psp) nxt = S_PAUSE; else if (plp) begin nxt = S_LAP; lat = 1'b1; end
      S_LAP:   if (psp) nxt = S_PAUSE; else if (plp) nxt = S_RUN;
      S_PAUSE: if (pcp) begin nxt = S_IDLE; clr = 1'b1; end else if (psp) nxt = S_RUN;
      default: nxt = S_IDLE;
    endcase
    if (nxt != m_state || clr || lat) begin
      if (nxt == S_PAUSE) m_toggle_at = t + BLINK;
      m_blank = 1'b0;
      m_state = nxt;
      push(t, pack(clr, lat));
      if (clr || lat) push(t + 1, pack(1'b0, 1'b0));
    end
  endtask

  task automatic wait_cycles(input int n);
    advance_to(edge_n + n + 1);
    repeat (n) @(negedge clk);
  endtask

  // Hold the given buttons for 'hold' cycles, then release and let them settle
  task automatic press(input logic psp, input logic plp, input logic pcp, input int hold);
    int t;
    t = edge_n + 1 + LAT;
    if (hold >= DEB) begin
      advance_to(t);
      model_step(psp, plp, pcp, t);
    end
    sp = psp;
    lp = plp;
    cp = pcp;
    wait_cycles(hold);
    sp = 1'b0;
    lp = 1'b0;
    cp = 1'b0;
    wait_cycles(GAP);
  endtask

  // Monitor: each output change is one transaction
  always @(negedge clk) begin
    #1;
    if (mon_en) begin
      cur_vec = {o_state, o_cnt_en, o_cnt_clr, o_lap_latch, o_lap_hold, o_blank};
      if (cur_vec !== prev_vec) begin
        $display("edge %0d: state=%0d en=%b clr=%b latch=%b hold=%b blank=%b",
                 edge_n, o_state, o_cnt_en, o_cnt_clr, o_lap_latch, o_lap_hold, o_blank);
        if (exp_q.size() == 0) begin
          check("pending_events", exp_q.size(), 1);
        end else begin
          rec = exp_q.pop_front();
          check("event_edge", edge_n, rec.cyc);
          check("event_outputs", cur_vec, rec.val);
        end
        prev_vec = cur_vec;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int r;
    repeat (3) @(negedge clk);
    check("rst_state",     o_state, 0);
    check("rst_cnt_en",    o_cnt_en, 0);
    check("rst_cnt_clr",   o_cnt_clr, 0);
    check("rst_lap_latch", o_lap_latch, 0);
    check("rst_lap_hold",  o_lap_hold, 0);
    check("rst_blank",     o_blank, 0);
    rst      = 1'b0;
    prev_vec = '0;
    mon_en   = 1'b1;
    wait_cycles(5);

    // 1: start from IDLE, release is silent
    press(1'b1, 1'b0, 1'b0, 30);
    // 2: lap glitch ignored, real lap freezes, second lap releases
    press(1'b0, 1'b1, 1'b0, 15);
    press(1'b0, 1'b1, 1'b0, 25);
    press(1'b0, 1'b1, 1'b0, 25);
    // 3: pause with blink, resume while blanked
    press(1'b1, 1'b0, 1'b0, 30);
    wait_cycles(700);
    press(1'b1, 1'b0, 1'b0, 30);
    // 4: clear + start/stop together in PAUSE -> clear wins
    press(1'b1, 1'b0, 1'b0, 30);
    press(1'b1, 1'b0, 1'b1, 30);
    // 5: clear ignored in RUN, honoured in IDLE
    press(1'b1, 1'b0, 1'b0, 30);
    press(1'b0, 1'b0, 1'b1, 30);
    press(1'b1, 1'b0, 1'b0, 30);
    press(1'b0, 1'b0, 1'b1, 30);
    press(1'b0, 1'b0, 1'b1, 30);
    // 6: reset in LAP with start/stop held through it
    press(1'b1, 1'b0, 1'b0, 30);
    press(1'b0, 1'b1, 1'b0, 25);
    wait_cycles(100);
    sp = 1'b1;
    @(negedge clk);
    r = edge_n + 1;
    advance_to(r);
    m_state = S_IDLE;
    m_blank = 1'b0;
    push(r, pack(1'b0, 1'b0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_step(1'b1, 1'b0, 1'b0, r + 1 + LAT);
    wait_cycles(30);
    sp = 1'b0;
    wait_cycles(GAP + 20);

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
